// File: rtl/rom_pkg.sv
// Shared constants, response payload and occupancy type for the pipelined instruction ROM.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rom_pkg;

   localparam logic [6:0]  OPC_LUI   = 7'h37;
   localparam logic [6:0]  OPC_OPIMM = 7'h13;
   localparam logic [4:0]  REG_SP    = 5'd2;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

   // Number of response entries the ROM may hold (pipeline register + skid).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } rom_occ_t;

   typedef struct packed {
      logic        err;
      logic [31:0] dat;
   } rom_rsp_t;

   // Boot sequence: word 0 = lui sp,hi ; word 1 = addi sp,sp,lo.
   // hi is rounded by +0x800 so a negative (sign-extended) lo lands on stack_top.
   function automatic logic [31:0] boot_word(input logic idx, input logic [31:0] stack_top);
      logic [19:0] hi20;
      logic [11:0] lo12;
      hi20 = 20'((stack_top + 32'h0000_0800) >> 12);
      lo12 = stack_top[11:0];
      if (!idx) begin
         return {hi20, REG_SP, OPC_LUI};
      end
      return {lo12, REG_SP, 3'b000, REG_SP, OPC_OPIMM};
   endfunction

endpackage

// File: rtl/rom_skid_buffer.sv
// Two-entry response store: newest entry lives in the ROM output register, older one in a skid register.
// Latency: response visible the cycle after accept; strict FIFO order.
// Backpressure: push_ready drops only when both entries are full and the head is not being popped.
module rom_skid_buffer
   import rom_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   input  logic     push_valid,
   output logic     push_ready,
   output logic     load_en,
   input  rom_rsp_t head_in,
   output logic     pop_valid,
   input  logic     pop_ready,
   output rom_rsp_t pop_data
);

   rom_occ_t occ_d, occ_q;
   rom_rsp_t skid_d, skid_q;
   logic     accept;
   logic     pop;

   // Handshakes and output selection: the skid entry is always the older one when present.
   always_comb begin
      push_ready = (occ_q != TWO) || pop_ready;
      pop_valid  = (occ_q != EMPTY);
      accept     = push_valid && push_ready;
      pop        = pop_valid && pop_ready;
      load_en    = accept;
      pop_data   = (occ_q == TWO) ? skid_q : head_in;
   end

   // Next occupancy and skid contents; flush keeps only a same-cycle accept.
   always_comb begin
      occ_d  = occ_q;
      skid_d = skid_q;
      unique case (occ_q)
         EMPTY: begin
            if (accept) occ_d = ONE;
         end
         ONE: begin
            if (accept && !pop) begin
               occ_d  = TWO;
               skid_d = head_in;
            end else if (!accept && pop) begin
               occ_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               // The register entry becomes the head; a new read replaces it.
               skid_d = head_in;
               occ_d  = accept ? TWO : ONE;
            end
         end
         default: occ_d = EMPTY;
      endcase
      if (flush) begin
         occ_d = accept ? ONE : EMPTY;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_q  <= EMPTY;
         skid_q <= '0;
      end else begin
         occ_q  <= occ_d;
         skid_q <= skid_d;
      end
   end

endmodule

// File: rtl/inst_rom_pipelined.sv
// Pipelined fetch-stage instruction ROM with boot-word patch; optional fault trap via `ROM_ERR_TRAP_EN.
// Latency: one cycle from request accept to response; sustains one word per clock.
// Backpressure: two-entry response store; req_ready drops when full and rsp_ready is low.
module inst_rom_pipelined
   import rom_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter string       INIT_FILE   = "rom.hex",
   parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
   parameter bit          BOOT_PATCH  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   rom_mem [DEPTH_WORDS];
   logic [AW-1:0] word_idx;
   logic          fault;
   logic          load_en;
   logic [31:0]   fetch_word;
   rom_rsp_t      head_d, head_q;
   rom_rsp_t      out_rsp;

   assign word_idx = req_addr[2 +: AW];

`ifdef ROM_ERR_TRAP_EN
   assign fault = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH_WORDS * 4));
`else
   // Low bits ignored and the address wraps, so the remaining bits are deliberately dropped.
   logic unused_addr_bits;
   assign fault            = 1'b0;
   assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:AW+2]};
`endif

   // Array read, boot patch and fault substitution feeding the ROM output register.
   always_comb begin
      fetch_word = rom_mem[word_idx];
      if (BOOT_PATCH && (word_idx[AW-1:1] == '0)) begin
         fetch_word = boot_word(word_idx[0], STACK_TOP);
      end
      head_d = head_q;
      if (load_en) begin
         head_d.err = fault;
         head_d.dat = fault ? NOP_WORD : fetch_word;
      end
   end

   // ROM output register: holds the newest accepted response until the next accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) head_q <= '0;
      else       head_q <= head_d;
   end

   rom_skid_buffer u_skid (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push_valid (req_valid),
      .push_ready (req_ready),
      .load_en    (load_en),
      .head_in    (head_q),
      .pop_valid  (rsp_valid),
      .pop_ready  (rsp_ready),
      .pop_data   (out_rsp)
   );

   assign rsp_data = out_rsp.dat;

`ifdef ROM_ERR_TRAP_EN
   assign rsp_err = out_rsp.err;
`else
   logic unused_err;
   assign rsp_err    = 1'b0;
   assign unused_err = out_rsp.err;
`endif

endmodule

// File: tb/tb_inst_rom_pipelined.sv
`timescale 1ns/1ps
module tb_inst_rom_pipelined;

   localparam int          DEPTH = 64;
   localparam logic [31:0] ST_A  = 32'h0000_1000;
   localparam logic [31:0] ST_B  = 32'h0000_1800;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        rsp_ready = 1'b0;
   logic [31:0] req_addr = '0;

   logic        req_ready_a, rsp_valid_a, rsp_err_a;
   logic [31:0] rsp_data_a;
   logic        req_ready_b, rsp_valid_b, rsp_err_b;
   logic [31:0] rsp_data_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] image [DEPTH];
   logic [32:0] q_a [$];
   logic [32:0] q_b [$];

   always #5 clk = ~clk;

   inst_rom_pipelined #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .STACK_TOP(ST_A), .BOOT_PATCH(1'b1)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready_a), .req_addr(req_addr),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a)
   );

   inst_rom_pipelined #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .STACK_TOP(ST_B), .BOOT_PATCH(1'b1)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready_b), .req_addr(req_addr),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
   );

   // Reference: what a fetch of byte address addr must return, as {err, data}.
   function automatic logic [32:0] model(input logic [31:0] addr, input logic [31:0] st);
      int          idx;
      logic [31:0] hi;
      logic [31:0] lo;
      idx = int'((addr / 4) % DEPTH);
`ifdef ROM_ERR_TRAP_EN
      if ((addr % 4) != 0 || addr >= 32'(DEPTH * 4)) return {1'b1, 32'h0000_0013};
`endif
      hi = (st + 32'h800) / 4096;
      lo = st % 4096;
      if (idx == 0) return {1'b0, hi[19:0], 5'd2, 7'h37};
      if (idx == 1) return {1'b0, lo[11:0], 5'd2, 3'b000, 5'd2, 7'h13};
      return {1'b0, image[idx]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // One bus cycle: drive after the edge, record acceptance and flush after the monitor ran.
   task automatic cyc(input bit v, input logic [31:0] a, input bit rdy, input bit fl);
      @(posedge clk); #1;
      req_valid = v;
      req_addr  = a;
      rsp_ready = rdy;
      flush     = fl;
      @(negedge clk); #1;
      if (fl) begin
         q_a.delete();
         q_b.delete();
      end
      if (v && req_ready_a) begin
         q_a.push_back(model(a, ST_A));
         q_b.push_back(model(a, ST_B));
      end
   endtask

   // Monitor: compares handshake signals and the head response against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("req_ready_a", 64'(req_ready_a), 64'((q_a.size() < 2) || rsp_ready));
            chk("rsp_valid_a", 64'(rsp_valid_a), 64'(q_a.size() != 0));
            if (rsp_valid_a && q_a.size() != 0) begin
               chk("rsp_a", 64'({rsp_err_a, rsp_data_a}), 64'(q_a[0]));
               if (rsp_ready) void'(q_a.pop_front());
            end
            chk("req_ready_b", 64'(req_ready_b), 64'((q_b.size() < 2) || rsp_ready));
            chk("rsp_valid_b", 64'(rsp_valid_b), 64'(q_b.size() != 0));
            if (rsp_valid_b && q_b.size() != 0) begin
               chk("rsp_b", 64'({rsp_err_b, rsp_data_b}), 64'(q_b[0]));
               if (rsp_ready) void'(q_b.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         image[i] = $urandom;
         dut_a.rom_mem[i] = image[i];
         dut_b.rom_mem[i] = image[i];
      end
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid_a), 64'(0));
      chk("reset_rsp_data", 64'(rsp_data_a), 64'(0));
      chk("reset_rsp_err", 64'(rsp_err_a), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Boot words.
      cyc(1, 32'h0, 1, 0);
      cyc(1, 32'h4, 1, 0);
      cyc(0, 32'h0, 1, 0);

      // Back-to-back stream.
      for (int a = 8; a <= 32'h20; a += 4) cyc(1, 32'(a), 1, 0);

      // Stall during a stream, then release.
      for (int i = 0; i < 8; i++) cyc(1, 32'(32'h24 + 4 * i), !(i >= 2 && i < 6), 0);
      cyc(0, 32'h0, 1, 0);
      cyc(0, 32'h0, 1, 0);

      // Two in flight, flush with redirect to 0x40 while the head is consumed.
      cyc(1, 32'h80, 0, 0);
      cyc(1, 32'h84, 0, 0);
      cyc(1, 32'h40, 1, 1);
      cyc(0, 32'h0, 1, 0);
      cyc(0, 32'h0, 1, 0);

      // Flush with nothing accepted.
      cyc(1, 32'h88, 0, 0);
      cyc(1, 32'h8c, 0, 0);
      cyc(0, 32'h0, 0, 1);
      cyc(0, 32'h0, 1, 0);

      // Misaligned and out-of-range addresses.
      cyc(1, 32'h2, 1, 0);
      cyc(1, 32'(DEPTH * 4), 1, 0);
      cyc(1, 32'(DEPTH * 4 + 8), 1, 0);
      cyc(1, 32'h7, 1, 0);
      cyc(0, 32'h0, 1, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = $urandom_range(0, DEPTH * 8 - 1);
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
      end

      // Reset in the middle of a stalled stream.
      cyc(1, 32'h10, 0, 0);
      cyc(1, 32'h14, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      req_valid = 1'b0;
      flush = 1'b0;
      q_a.delete();
      q_b.delete();
      #1;
      chk("midreset_rsp_valid", 64'(rsp_valid_a), 64'(0));
      chk("midreset_rsp_data", 64'(rsp_data_a), 64'(0));
      chk("midreset_req_ready", 64'(req_ready_a), 64'(1));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      cyc(1, 32'h0, 1, 0);
      cyc(1, 32'h30, 1, 0);

      for (int i = 0; i < 10 && (q_a.size() != 0 || q_b.size() != 0); i++) cyc(0, 32'h0, 1, 0);
      chk("drain_a", 64'(q_a.size()), 64'(0));
      chk("drain_b", 64'(q_b.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
